// File: rtl/core_insn_loader_if.sv
// Scheduler-to-core instruction-frame bus: Start/counter/data burst, R0 init vectors and Ready.
// The scheduler drives through 'master'; each core's loader listens through 'slave'.
interface core_insn_loader_if #(
  parameter int unsigned NUM_OF_CORES   = 4,
  parameter int unsigned CNT_WIDTH      = 2,
  parameter int unsigned INSN_BUS_WIDTH = 64,
  parameter int unsigned REG_WIDTH      = 8
);
  logic [NUM_OF_CORES-1:0]           start;
  logic [CNT_WIDTH-1:0]              insn_load_cnt;
  logic [INSN_BUS_WIDTH-1:0]         insn_data;
  logic [NUM_OF_CORES-1:0]           init_r0_vect;
  logic [NUM_OF_CORES*REG_WIDTH-1:0] init_r0;
  logic                              ready;

  modport master (
    output start,
    output insn_load_cnt,
    output insn_data,
    output init_r0_vect,
    output init_r0,
    input  ready
  );

  modport slave (
    input  start,
    input  insn_load_cnt,
    input  insn_data,
    input  init_r0_vect,
    input  init_r0,
    output ready
  );
endinterface

// File: rtl/core_insn_loader.sv
// Per-core receive stage: captures a scheduler instruction-frame burst into a local buffer,
// hands it to the core pipeline and applies the initial R0 value once per control frame.
module core_insn_loader #(
  parameter int unsigned CORE_ID        = 0,
  parameter int unsigned NUM_OF_CORES   = 4,
  parameter int unsigned INSN_LOAD_TIME = 4,
  parameter int unsigned INSN_BUS_WIDTH = 64,
  parameter int unsigned INSN_WIDTH     = 16,
  parameter int unsigned REG_WIDTH      = 8,
  parameter int unsigned CNT_WIDTH      = 2,
  localparam int unsigned IPF           = INSN_LOAD_TIME * INSN_BUS_WIDTH / INSN_WIDTH,
  localparam int unsigned AW            = $clog2(IPF)
) (
  input  logic                  clk,
  input  logic                  reset,
  core_insn_loader_if.slave     bus,
  input  logic [AW-1:0]         fetch_addr_i,
  output logic                  run_o,
  output logic [INSN_WIDTH-1:0] fetch_insn_o,
  input  logic                  core_done_i,
  output logic                  r0_we_o,
  output logic [REG_WIDTH-1:0]  r0_data_o,
  output logic                  load_err_o
);

  localparam int unsigned IPB = INSN_BUS_WIDTH / INSN_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LastBeat = CNT_WIDTH'(INSN_LOAD_TIME - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   exp_q, exp_d;
  logic                   err_q, err_d;
  logic                   r0_we_q, r0_we_d;
  logic [REG_WIDTH-1:0]   r0_data_q, r0_data_d;
  logic                   applied_q, applied_d;
  logic                   wr_en;
  logic [INSN_WIDTH-1:0]  fetch_insn_q;
  logic [INSN_WIDTH-1:0]  mem_q [IPF];

  logic                   s;
  logic                   vect;
  logic [REG_WIDTH-1:0]   r0_slice;

  assign s        = bus.start[CORE_ID];
  assign vect     = bus.init_r0_vect[CORE_ID];
  assign r0_slice = bus.init_r0[CORE_ID*REG_WIDTH +: REG_WIDTH];

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    err_d     = err_q;
    wr_en     = 1'b0;
    r0_we_d   = 1'b0;
    r0_data_d = r0_data_q;
    applied_d = vect ? applied_q : 1'b0;

    unique case (state_q)
      StIdle: begin
        if (s) begin
          if (bus.insn_load_cnt == '0) begin
            wr_en = 1'b1;
            if (INSN_LOAD_TIME == 1) begin
              state_d = StRun;
            end else begin
              state_d = StLoad;
              exp_d   = CNT_WIDTH'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (!s) begin
          state_d = StIdle;
        end else if (bus.insn_load_cnt == exp_q) begin
          wr_en = 1'b1;
          if (exp_q == LastBeat) begin
            state_d = StRun;
          end else begin
            exp_d = exp_q + CNT_WIDTH'(1);
          end
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StRun: begin
        if (s) begin
          err_d = 1'b1;
        end
        if (core_done_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // R0 strobe lands in the same cycle run rises, once per control frame.
    if (state_q != StRun && state_d == StRun && vect && !applied_q) begin
      r0_we_d   = 1'b1;
      r0_data_d = r0_slice;
      applied_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      exp_q     <= '0;
      err_q     <= 1'b0;
      r0_we_q   <= 1'b0;
      r0_data_q <= '0;
      applied_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      r0_we_q   <= r0_we_d;
      r0_data_q <= r0_data_d;
      applied_q <= applied_d;
    end
  end

  // Frame buffer is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      for (int unsigned k = 0; k < IPB; k++) begin
        mem_q[AW'(int'(bus.insn_load_cnt) * IPB + k)] <=
            bus.insn_data[k*INSN_WIDTH +: INSN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_insn_q <= '0;
    end else begin
      fetch_insn_q <= mem_q[fetch_addr_i];
    end
  end

  assign bus.ready    = (state_q != StRun);
  assign run_o        = (state_q == StRun);
  assign fetch_insn_o = fetch_insn_q;
  assign r0_we_o      = r0_we_q;
  assign r0_data_o    = r0_data_q;
  assign load_err_o   = err_q;

endmodule

// File: doc/core_insn_loader.md
Name: core_insn_loader

Overview:
- Per-core receive stage sitting directly downstream of the task scheduler; one instance per core, selected by CORE_ID.
- Captures the multi-cycle instruction-frame burst (Start / Insn_Load_Counter / Insn_Data) into a local frame buffer.
- Hands the complete frame to the core pipeline and reports Ready back to the scheduler.
- Applies the per-core initial R0 value when the scheduler selects it.

Parameters:
- CORE_ID, 0, index of this core; selects the Start, Init_R0_Vect and Init_R0 slices.
- NUM_OF_CORES, 4, width of the scheduler's core vectors.
- INSN_LOAD_TIME, 4, bus beats per instruction frame.
- INSN_BUS_WIDTH, 64, width of Insn_Data per beat.
- INSN_WIDTH, 16, width of one instruction; INSN_BUS_WIDTH must be a multiple of it.
- REG_WIDTH, 8, width of R0.
- CNT_WIDTH, 2, width of Insn_Load_Counter; must satisfy 2^CNT_WIDTH >= INSN_LOAD_TIME.
- Derived: IPF = INSN_LOAD_TIME*INSN_BUS_WIDTH/INSN_WIDTH instructions per frame; AW = clog2(IPF).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  NUM_OF_CORES  scheduler Start vector
- insn_load_cnt  in  CNT_WIDTH  beat index of current Insn_Data
- insn_data  in  INSN_BUS_WIDTH  frame beat
- init_r0_vect  in  NUM_OF_CORES  per-core R0-init select
- init_r0  in  NUM_OF_CORES*REG_WIDTH  packed R0 values; core i occupies bits [i*REG_WIDTH +: REG_WIDTH]
- ready  out  1  to scheduler Ready[CORE_ID]
- run  out  1  frame valid, core may execute
- fetch_addr  in  AW  core instruction fetch index
- fetch_insn  out  INSN_WIDTH  instruction at fetch_addr
- core_done  in  1  core finished frame (pulse or level)
- r0_we  out  1  one-cycle R0 write strobe
- r0_data  out  REG_WIDTH  R0 write value
- load_err  out  1  sticky protocol-error flag

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: state IDLE, ready=1, run=0, r0_we=0, r0_data=0, load_err=0, fetch_insn=0, r0_applied=0. Frame buffer contents are not reset.
- Local start bit: s = start[CORE_ID].
- States: IDLE, LOAD, RUN. Outputs are registered or decoded from state only; no input-to-output combinational path except none.
- ready = (state != RUN). Ready stays high during LOAD because the scheduler drops Start if Ready falls mid-burst.
- Beat capture: every cycle with s=1 and state in IDLE or LOAD, write insn_data into buffer beat slot insn_load_cnt. Instruction k of beat b sits at buffer index b*(INSN_BUS_WIDTH/INSN_WIDTH)+k, with k=0 in the LSBs.
- IDLE -> LOAD: s=1 and insn_load_cnt=0. If s=1 with insn_load_cnt!=0: set load_err, ignore the beat, stay IDLE.
- LOAD: an internal expected counter increments per beat.
  - s=1 with insn_load_cnt != expected: set load_err, go to IDLE, discard the partial frame.
  - s=0 mid-burst: abort to IDLE, no error.
- LOAD -> RUN: on capture of beat INSN_LOAD_TIME-1. ready is 0 and run is 1 in the very next cycle.
- Special case INSN_LOAD_TIME=1: IDLE -> RUN directly on a cnt=0 beat.
- RUN: any s=1 sets load_err and is ignored; the buffer is write-protected.
- RUN -> IDLE: on core_done=1. ready=1 and run=0 from the next cycle. core_done in IDLE or LOAD is ignored.
- Fetch: fetch_insn <= buffer[fetch_addr] every cycle; 1-cycle latency. Reading in any state is legal.
- R0 init:
  - r0_applied clears whenever init_r0_vect[CORE_ID]=0.
  - On the LOAD->RUN transition cycle, if init_r0_vect[CORE_ID]=1 and r0_applied=0: r0_we=1 for exactly one cycle, coincident with run rising; r0_data = this core's slice of init_r0; r0_applied is set.
  - r0_data holds its value after the strobe.
  - Once applied, later frames under the same control frame do not re-apply R0.
- load_err clears only on reset.
- Reset mid-LOAD or mid-RUN: returns to IDLE next cycle, run=0, ready=1, no r0_we.
- Size target: about 150-250 lines of RTL.

Test Plan:
- Nominal load (INSN_LOAD_TIME=4, CORE_ID=1): start=4'b0010 for 4 cycles, cnt 0..3, data 64'h0003_0002_0001_0000 + beat*64'h0004_0004_0004_0004 -> ready=1 through beat 3; next cycle ready=0, run=1; fetch_addr=5 gives fetch_insn=16'h0005 one cycle later.
- Completion: core_done pulsed in RUN -> next cycle ready=1, run=0; a second burst loads new data and fetch returns the new values.
- R0 init: init_r0_vect=4'b0010, init_r0=32'h44_33_22_11 across two consecutive frames -> single r0_we pulse with r0_data=8'h22 on the first frame's run rise; none on the second. Drop vect to 0, raise it again, load -> r0_we fires again.
- Protocol errors:
  - Burst starting at cnt=2 -> load_err=1, state stays IDLE.
  - After reset, burst with cnt sequence 0,1,3 -> load_err=1, return to IDLE, run never asserts.
  - start asserted during RUN -> load_err=1, buffer unchanged.
- Abort and reset: start drops after beat 1 -> IDLE, load_err=0, ready=1. Reset asserted in RUN -> next cycle run=0, ready=1, load_err=0.
- Other-core isolation: start=4'b0001 full burst with CORE_ID=1 -> no state change, buffer untouched, ready stays 1.
